// File: rtl/data_mem_pkg.sv
// Shared types and sizes for the data_mem slow main-memory model.
// Optional block sweep on reset is enabled by defining DATA_MEM_CLEAR_EN.
package data_mem_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int ADDR_W          = 10;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int DEPTH           = 256;
    localparam int WIDX_W          = 8;
    localparam int BIDX_W          = 6;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // Block index of a word index: drop the word-in-block bits.
    function automatic logic [BIDX_W-1:0] block_of(input logic [WIDX_W-1:0] widx);
        return widx[WIDX_W-1:2];
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// 256x32 word storage: one word-write port, one 4-word block-read port, and a
// whole-block clear port used only when DATA_MEM_CLEAR_EN is defined.
module data_mem_array
    import data_mem_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [WIDX_W-1:0]   wr_idx,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic                clr_en,
    input  logic [BIDX_W-1:0]   clr_blk,
    input  logic [BIDX_W-1:0]   rd_blk,
    output logic [BLOCK_W-1:0]  rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

    // Storage update: a block clear takes precedence over a word write.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
                mem_q[{clr_blk, 2'(w)}] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Block read: word 0 lands in the least-significant lane.
    always_comb begin
        rd_data = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            rd_data[w*WORD_W +: WORD_W] = mem_q[{rd_blk, 2'(w)}];
        end
    end

endmodule

// File: rtl/data_mem.sv
// Multi-cycle data memory with a level ready handshake and fixed latency.
// Define DATA_MEM_CLEAR_EN to zero all contents with a 64-cycle sweep on rst.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WORD_W-1:0]   data_in,
    output logic [BLOCK_W-1:0]  data_out,
    output logic                ready
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);
`ifdef DATA_MEM_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_op_q, wr_op_d;
    logic [WIDX_W-1:0]    widx_q, widx_d;
    logic [WORD_W-1:0]    wdata_q, wdata_d;
    logic [BLOCK_W-1:0]   data_out_q, data_out_d;
    logic                 ready_q, ready_d;
    logic [BIDX_W-1:0]    clr_blk_q, clr_blk_d;

    logic                 acc_en_s;
    logic                 acc_wr_s;
    logic [WIDX_W-1:0]    acc_widx_s;
    logic [WORD_W-1:0]    acc_wdata_s;
    logic                 clr_en_s;
    logic [BLOCK_W-1:0]   rd_data_s;
    logic [1:0]           unused_byte_off_s;

    assign unused_byte_off_s = addr[1:0];

    // Next-state, access strobe and output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_op_d     = wr_op_q;
        widx_d      = widx_q;
        wdata_d     = wdata_q;
        data_out_d  = data_out_q;
        clr_blk_d   = clr_blk_q;
        acc_en_s    = 1'b0;
        acc_wr_s    = wr_op_q;
        acc_widx_s  = widx_q;
        acc_wdata_s = wdata_q;
        clr_en_s    = 1'b0;

        if (rst) begin
            state_d    = RESET_STATE;
            cnt_d      = '0;
            data_out_d = '0;
            clr_blk_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MemRead || MemWrite) begin
                        wr_op_d = MemWrite;
                        widx_d  = addr[ADDR_W-1:2];
                        wdata_d = data_in;
                        if (ACCESS_CYCLES == 1) begin
                            // Single-cycle latency: access straight from the pins.
                            acc_en_s    = 1'b1;
                            acc_wr_s    = MemWrite;
                            acc_widx_s  = addr[ADDR_W-1:2];
                            acc_wdata_s = data_in;
                            cnt_d       = '0;
                            state_d     = ST_DONE;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = ST_BUSY;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        acc_en_s = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!MemRead && !MemWrite) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
`ifdef DATA_MEM_CLEAR_EN
                ST_CLEAR: begin
                    clr_en_s  = 1'b1;
                    clr_blk_d = clr_blk_q + 6'd1;
                    if (clr_blk_q == 6'd63) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (acc_en_s && !acc_wr_s) begin
            data_out_d = rd_data_s;
        end else begin
            data_out_d = data_out_d;
        end
        ready_d = (state_d == ST_DONE);
    end

    // State and output registers, synchronous reset handled in the next-state logic.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        wr_op_q    <= wr_op_d;
        widx_q     <= widx_d;
        wdata_q    <= wdata_d;
        data_out_q <= data_out_d;
        ready_q    <= rst ? 1'b0 : ready_d;
        clr_blk_q  <= clr_blk_d;
    end

    data_mem_array u_array (
        .clk     (clk),
        .wr_en   (acc_en_s & acc_wr_s),
        .wr_idx  (acc_widx_s),
        .wr_data (acc_wdata_s),
        .clr_en  (clr_en_s),
        .clr_blk (clr_blk_q),
        .rd_blk  (block_of(acc_widx_s)),
        .rd_data (rd_data_s)
    );

    assign data_out = data_out_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expected blocks, a monitor
// checks data_out and latency on every rising edge of ready.
module tb_data_mem;

    localparam int AC = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         MemRead = 1'b0;
    logic         MemWrite = 1'b0;
    logic [9:0]   addr = 10'd0;
    logic [31:0]  data_in = 32'd0;
    logic [127:0] data_out;
    logic         ready;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [127:0] data;
        int           acc;
        string        name;
    } exp_t;
    exp_t sb_q[$];

    data_mem #(.ACCESS_CYCLES(AC)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every rising ready must match the oldest outstanding expectation.
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b1 && ready_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready=1 at cycle %0d, expected no response", cyc);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_data"}, data_out, e.data);
                chk({e.name, "_latency"}, 128'(cyc - e.acc), 128'(AC));
            end
        end
        ready_prev = ready;
    end

    task automatic request(input logic rd, input logic wr, input logic [9:0] a,
                           input logic [31:0] d, input logic [127:0] exp,
                           input string nm, input int hold);
        exp_t e;
        bit   got;
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        addr     = a;
        data_in  = d;
        e.data = exp;
        e.acc  = cyc + 1;
        e.name = nm;
        sb_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no ready in 40 cycles, expected ready", nm);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_ready_held"}, 128'(ready), 128'(1));
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_fall"}, 128'(ready), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_ready", 128'(ready), 128'(0));
        chk("reset_data_out", data_out, 128'd0);
`ifdef DATA_MEM_CLEAR_EN
        repeat (64) @(negedge clk);
`endif

        request(1'b0, 1'b1, 10'd5, 32'd8, 128'd0, "wr5", 3);
        request(1'b1, 1'b0, 10'd3, 32'd0,
                128'h00000000_00000000_00000008_00000000, "rd3", 1);
        request(1'b1, 1'b0, 10'd5, 32'd0,
                128'h00000000_00000000_00000008_00000000, "rd5", 1);
        request(1'b0, 1'b1, 10'h3FC, 32'hA5A5A5A5,
                128'h00000000_00000000_00000008_00000000, "wr3fc", 1);
        request(1'b1, 1'b0, 10'h3F0, 32'd0,
                128'hA5A5A5A5_00000000_00000000_00000000, "rd3f0", 1);
        request(1'b1, 1'b1, 10'd0, 32'd7,
                128'hA5A5A5A5_00000000_00000000_00000000, "both0", 1);
        request(1'b1, 1'b0, 10'd0, 32'd0,
                128'h00000000_00000000_00000008_00000007, "rd0", 1);

        // Reset pulsed while a write of 9 to addr 8 is in BUSY.
        @(negedge clk);
        MemWrite = 1'b1;
        addr     = 10'd8;
        data_in  = 32'd9;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        MemWrite = 1'b0;
        chk("abort_data_out", data_out, 128'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_ready", 128'(ready), 128'(0));
        end
`ifdef DATA_MEM_CLEAR_EN
        repeat (64) @(negedge clk);
        request(1'b1, 1'b0, 10'd8, 32'd0, 128'd0, "rd8_after_abort", 1);
        request(1'b1, 1'b0, 10'h3F0, 32'd0, 128'd0, "rd3f0_after_clear", 1);
`else
        request(1'b1, 1'b0, 10'd8, 32'd0,
                128'h00000000_00000000_00000008_00000007, "rd8_after_abort", 1);
        request(1'b1, 1'b0, 10'h3F0, 32'd0,
                128'hA5A5A5A5_00000000_00000000_00000000, "rd3f0_after_reset", 1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
